// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcode constants, state encoding and decode record for the control-transfer sequencer
package mips_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FUNCT_JR   = 6'h08;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic j;
    logic jal;
    logic jr;
    logic beq;
    logic bne;
  } xfer_t;

endpackage

// File: rtl/branch_target_calc.sv
// rtl/branch_target_calc.sv - decodes the transfer type of the decode-stage word and computes every candidate target
module branch_target_calc
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] dec_pc,
  input  logic [31:0] dec_instr,
  input  logic [31:0] rs_data,
  output logic [31:0] seq_pc,
  output logic [31:0] jump_target,
  output logic [31:0] branch_target,
  output logic [31:0] jr_target,
  output xfer_t       xfer
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] imm_ext;

  assign opcode = dec_instr[31:26];
  assign funct  = dec_instr[5:0];

  assign imm_ext = {{16{dec_instr[15]}}, dec_instr[15:0]};

  assign seq_pc        = dec_pc + PC_STEP;
  assign jump_target   = {seq_pc[31:28], dec_instr[25:0], 2'b00};
  assign branch_target = seq_pc + (imm_ext << 2);
  // JR ignores the low two bits of the register so the target is always word aligned
  assign jr_target     = rs_data & 32'hFFFF_FFFC;

  always_comb begin
    xfer     = '0;
    xfer.j   = (opcode == OP_J);
    xfer.jal = (opcode == OP_JAL);
    xfer.jr  = (opcode == OP_SPECIAL) && (funct == FUNCT_JR);
    xfer.beq = (opcode == OP_BEQ);
    xfer.bne = (opcode == OP_BNE);
  end

endmodule

// File: rtl/jump_pc_sequencer.sv
// rtl/jump_pc_sequencer.sv - fetch PC register and J/JAL/JR/BEQ/BNE redirect sequencer
// Optional build macro MIPS_DELAY_SLOT_EN: keep the delay-slot instruction and link to dec_pc+8.
module jump_pc_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_ready,
  input  logic        dec_valid,
  input  logic [31:0] dec_pc,
  input  logic [31:0] dec_instr,
  input  logic [31:0] rs_data,
  input  logic        branch_taken,
  output logic [31:0] pc,
  output logic        fetch_kill,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        busy_pending
);

  seq_state_t  state, state_next;
  logic [31:0] pc_next;
  logic [31:0] target_q;
  logic [31:0] target;
  logic        transfer;

  logic [31:0] seq_pc;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] jr_target;
  xfer_t       xfer;

  branch_target_calc u_calc (
    .dec_pc        (dec_pc),
    .dec_instr     (dec_instr),
    .rs_data       (rs_data),
    .seq_pc        (seq_pc),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .jr_target     (jr_target),
    .xfer          (xfer)
  );

  assign transfer = dec_valid &
                    (xfer.j | xfer.jal | xfer.jr | ((xfer.beq | xfer.bne) & branch_taken));

  always_comb begin
    target = branch_target;
    if (xfer.j || xfer.jal) target = jump_target;
    else if (xfer.jr)       target = jr_target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      pc       <= RESET_PC;
      target_q <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == RUN && transfer && !fetch_ready) target_q <= target;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      RUN: begin
        if (fetch_ready) pc_next = transfer ? target : pc + PC_STEP;
        else if (transfer) state_next = PEND;
      end
      PEND: begin
        // decode holds a bubble here, so dec_valid is deliberately not consulted
        if (fetch_ready) begin
          pc_next    = target_q;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    fetch_kill   = 1'b0;
    link_we      = (state == RUN) && dec_valid && xfer.jal;
    busy_pending = (state == PEND);
`ifdef MIPS_DELAY_SLOT_EN
    link_data    = seq_pc + PC_STEP;
`else
    link_data    = seq_pc;
    fetch_kill   = fetch_ready && ((state == PEND) || transfer);
`endif
  end

endmodule
